sub_2p: RTL

SUB_2P -- requirements
Module: sub_2p

---
 rtl/sub_pkg.sv | 9 +
 rtl/sub_half.sv | 22 ++
 rtl/sub_2p.sv | 113 +++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared constants for the two-stage pipelined subtractor.
//   WIDTH_DEF : default operand/result width (must be even)
//   HALF_DEF  : default width of each pipeline stage's slice
package sub_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned HALF_DEF  = WIDTH_DEF / 2;

endpackage : sub_pkg

// File: rtl/sub_half.sv
// Combinational slice subtractor: {bout, d} = a - b - bin.
// Ports:
//   a, b : W-bit operands
//   bin  : borrow in
//   d    : W-bit difference (mod 2^W)
//   bout : borrow out (a < b + bin)
module sub_half #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  // One extra bit captures the borrow as the sign of the widened result.
  always_comb begin
    {bout, d} = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
  end

endmodule : sub_half

// File: rtl/sub_2p.sv
// Two-stage pipelined subtractor with valid/ready handshaking.
// Stage 1 subtracts the low HALF bits; stage 2 subtracts the high slice
// with the stage-1 borrow and forms borrow/overflow flags.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   x, y       : minuend / subtrahend, accepted when in_valid && in_ready
//   in_valid   : x/y valid this cycle
//   in_ready   : combinational; pipeline can accept this cycle
//   diff       : x - y mod 2^WIDTH
//   borrow     : unsigned underflow (x < y)
//   ovf        : signed overflow of x - y
//   out_valid  : diff/borrow/ovf valid
//   out_ready  : downstream accepts result this cycle
// WIDTH must be even.
module sub_2p
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned HALF  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned HI = WIDTH - HALF;

  logic            s1_valid;
  logic [HALF-1:0] s1_lo;
  logic            b1;
  logic [HI-1:0]   x_hi;
  logic [HI-1:0]   y_hi;
  logic            s2_valid;

  logic            s1_adv;
  logic            s2_adv;
  logic [HALF-1:0] lo_d_c;
  logic            lo_b_c;
  logic [HI-1:0]   hi_d_c;
  logic            hi_b_c;
  logic            ovf_c;

  // Stall propagates backwards: a stage advances if it is empty or its successor advances.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  sub_half #(.W(HALF)) u_lo (
    .a    (x[HALF-1:0]),
    .b    (y[HALF-1:0]),
    .bin  (1'b0),
    .d    (lo_d_c),
    .bout (lo_b_c)
  );

  sub_half #(.W(HI)) u_hi (
    .a    (x_hi),
    .b    (y_hi),
    .bin  (b1),
    .d    (hi_d_c),
    .bout (hi_b_c)
  );

  // Signed overflow: operand signs differ and the result sign differs from x.
  assign ovf_c = (x_hi[HI-1] != y_hi[HI-1]) && (hi_d_c[HI-1] != x_hi[HI-1]);

  // Stage 1: low slice result plus high operands carried forward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      b1       <= 1'b0;
      x_hi     <= '0;
      y_hi     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      // Data only moves with a real transfer; bubbles update valid alone.
      if (in_valid) begin
        s1_lo <= lo_d_c;
        b1    <= lo_b_c;
        x_hi  <= x[WIDTH-1:HALF];
        y_hi  <= y[WIDTH-1:HALF];
      end
    end
  end

  // Stage 2: final result; holds while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      ovf      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        diff   <= {hi_d_c, s1_lo};
        borrow <= hi_b_c;
        ovf    <= ovf_c;
      end
    end
  end

endmodule : sub_2p
